// File: rtl/axil_gpio_slave.sv
// AXI4-Lite GPIO responder: DATA_OUT / TOGGLE / DATA_IN registers plus a gpi_i synchronizer.
// Define GPIO_IRQ_EN to add rising-edge IRQ_STATUS / IRQ_ENABLE registers and the irq output.
module axil_gpio_slave #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          GPIO_WIDTH  = 32,
    parameter logic [31:0] OUT_RESET   = 32'h0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    input  logic [GPIO_WIDTH-1:0] gpi_i,
    output logic                  irq
);
    localparam logic [2:0] IDX_DATA_OUT   = 3'd0;
    localparam logic [2:0] IDX_TOGGLE     = 3'd1;
    localparam logic [2:0] IDX_DATA_IN    = 3'd2;
    localparam logic [2:0] IDX_IRQ_STATUS = 3'd3;
    localparam logic [2:0] IDX_IRQ_ENABLE = 3'd4;
    localparam logic [1:0] RESP_OKAY      = 2'b00;
    localparam logic [1:0] RESP_SLVERR    = 2'b10;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // ready outputs are registered, so a master can sample them half a cycle ahead.
    logic                                  r_aw_held;
    logic                                  r_w_held;
    logic [2:0]                            r_aw_idx;
    logic [31:0]                           r_wdata;
    logic [3:0]                            r_wstrb;
    logic                                  r_awready;
    logic                                  r_wready;
    logic                                  r_bvalid;
    logic [1:0]                            r_bresp;
    logic                                  r_arready;
    logic                                  r_rvalid;
    logic [31:0]                           r_rdata;
    logic [1:0]                            r_rresp;
    logic [GPIO_WIDTH-1:0]                 r_data_out;
    logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_commit;
    logic                  w_aw_held_nx;
    logic                  w_w_held_nx;
    logic                  w_bvalid_nx;
    logic                  w_rvalid_nx;
    logic [31:0]           w_mask;
    logic [GPIO_WIDTH-1:0] w_mask_g;
    logic [GPIO_WIDTH-1:0] w_wbits_g;
    logic [GPIO_WIDTH-1:0] w_sync_out;
    logic [GPIO_WIDTH-1:0] w_irq_status;
    logic [GPIO_WIDTH-1:0] w_irq_enable;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    assign w_aw_hs      = s_axi_awvalid & r_awready;
    assign w_w_hs       = s_axi_wvalid & r_wready;
    assign w_ar_hs      = s_axi_arvalid & r_arready;
    assign w_commit     = r_aw_held & r_w_held;
    assign w_aw_held_nx = r_aw_held ? ~w_commit : w_aw_hs;
    assign w_w_held_nx  = r_w_held ? ~w_commit : w_w_hs;
    assign w_bvalid_nx  = r_bvalid ? ~s_axi_bready : w_commit;
    assign w_rvalid_nx  = r_rvalid ? ~s_axi_rready : w_ar_hs;
    assign w_mask       = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
    assign w_mask_g     = GPIO_WIDTH'(w_mask);
    assign w_wbits_g    = GPIO_WIDTH'(r_wdata & w_mask);
    assign w_sync_out   = r_sync[SYNC_STAGES-1];
    // Only addr[4:2] is decoded; the rest of both address buses is intentionally ignored.
    assign w_unused     = ^{s_axi_awaddr, s_axi_araddr};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= 3'd0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'h0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'h0;
            r_rresp    <= RESP_OKAY;
            r_data_out <= GPIO_WIDTH'(OUT_RESET);
            r_sync     <= '0;
        end else begin
            r_aw_held <= w_aw_held_nx;
            r_w_held  <= w_w_held_nx;
            r_bvalid  <= w_bvalid_nx;
            r_awready <= ~w_aw_held_nx & ~w_bvalid_nx;
            r_wready  <= ~w_w_held_nx & ~w_bvalid_nx;
            if (w_aw_hs) begin
                r_aw_idx <= s_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
            if (w_commit) begin
                r_bresp <= (r_aw_idx > IDX_IRQ_ENABLE) ? RESP_SLVERR : RESP_OKAY;
                case (r_aw_idx)
                    IDX_DATA_OUT: r_data_out <= (r_data_out & ~w_mask_g) | w_wbits_g;
                    IDX_TOGGLE:   r_data_out <= r_data_out ^ w_wbits_g;
                    default:      ;
                endcase
            end
            r_rvalid  <= w_rvalid_nx;
            r_arready <= ~w_rvalid_nx;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= w_rd_resp;
            end
            r_sync[0] <= gpi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

`ifdef GPIO_IRQ_EN
    logic [GPIO_WIDTH-1:0] r_gpi_prev;
    logic [GPIO_WIDTH-1:0] r_irq_status;
    logic [GPIO_WIDTH-1:0] r_irq_enable;
    logic                  r_irq;
    logic [GPIO_WIDTH-1:0] w_rise;
    logic [GPIO_WIDTH-1:0] w_clr;

    assign w_rise = w_sync_out & ~r_gpi_prev;
    assign w_clr  = (w_commit && r_aw_idx == IDX_IRQ_STATUS) ? w_wbits_g : '0;

    // A new edge is OR-ed in after the W1C clear so it is never lost to a same-cycle clear.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_gpi_prev   <= '0;
            r_irq_status <= '0;
            r_irq_enable <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_gpi_prev   <= w_sync_out;
            r_irq_status <= (r_irq_status & ~w_clr) | w_rise;
            if (w_commit && r_aw_idx == IDX_IRQ_ENABLE) begin
                r_irq_enable <= (r_irq_enable & ~w_mask_g) | w_wbits_g;
            end
            r_irq <= |(r_irq_status & r_irq_enable);
        end
    end

    assign w_irq_status = r_irq_status;
    assign w_irq_enable = r_irq_enable;
    assign irq          = r_irq;
`else
    assign w_irq_status = '0;
    assign w_irq_enable = '0;
    assign irq          = 1'b0;
`endif

    always_comb begin
        w_rd_data = 32'h0;
        w_rd_resp = RESP_OKAY;
        case (s_axi_araddr[4:2])
            IDX_DATA_OUT:   w_rd_data = 32'(r_data_out);
            IDX_DATA_IN:    w_rd_data = 32'(w_sync_out);
            IDX_IRQ_STATUS: w_rd_data = 32'(w_irq_status);
            IDX_IRQ_ENABLE: w_rd_data = 32'(w_irq_enable);
            3'd5, 3'd6, 3'd7: w_rd_resp = RESP_SLVERR;
            default:        w_rd_data = 32'h0;
        endcase
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign gpio_o        = r_data_out;

endmodule

// File: tb/tb_axil_gpio_slave.sv
// Directed + randomized bench for axil_gpio_slave against a register-level reference model.
// Builds with or without GPIO_IRQ_EN; the interrupt checks follow the same macro.
module tb_axil_gpio_slave;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [31:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] gpio_o;
    logic [31:0] gpi_i;
    logic        irq;

    logic        loopback = 1'b0;
    logic [31:0] gpi_drv = '0;
    assign gpi_i = loopback ? gpio_o : gpi_drv;

    always #5 ACLK = ~ACLK;

    axil_gpio_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .gpio_o(gpio_o), .gpi_i(gpi_i), .irq(irq)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: architectural register contents
    logic [31:0] m_out    = '0;
    logic [31:0] m_status = '0;
    logic [31:0] m_enable = '0;
    logic [31:0] m_gpi    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [1:0] resp);
        logic [31:0] m;
        m = byte_mask(strb);
        resp = 2'b00;
        case (addr[4:2])
            3'd0: m_out = (m_out & ~m) | (data & m);
            3'd1: m_out = m_out ^ (data & m);
            3'd3: if (IRQ_BUILD) m_status = m_status & ~(data & m);
            3'd4: if (IRQ_BUILD) m_enable = (m_enable & ~m) | (data & m);
            3'd5, 3'd6, 3'd7: resp = 2'b10;
            default: ;
        endcase
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        data = '0;
        resp = 2'b00;
        case (addr[4:2])
            3'd0: data = m_out;
            3'd2: data = m_gpi;
            3'd3: data = IRQ_BUILD ? m_status : 32'h0;
            3'd4: data = IRQ_BUILD ? m_enable : 32'h0;
            3'd5, 3'd6, 3'd7: resp = 2'b10;
            default: ;
        endcase
    endtask

    function automatic logic model_irq();
        return IRQ_BUILD ? (|(m_status & m_enable)) : 1'b0;
    endfunction

    // Drives AW and W independently with per-channel start delays, then holds bready low.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold,
                             output logic [1:0] resp);
        int cyc;
        int viol;
        bit aw_done, w_done, aw_hs, w_hs;
        viol = 0; cyc = 0; aw_done = 0; w_done = 0;
        @(negedge ACLK);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = (aw_dly == 0);
        s_axi_wvalid  = (w_dly == 0);
        while (!(aw_done && w_done) && cyc < 100) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            if (aw_done && s_axi_awready) viol++;
            if (w_done && s_axi_wready) viol++;
            @(negedge ACLK);
            cyc++;
            if (aw_hs) begin aw_done = 1; s_axi_awvalid = 1'b0; end
            if (w_hs) begin w_done = 1; s_axi_wvalid = 1'b0; end
            if (!aw_done && cyc >= aw_dly) s_axi_awvalid = 1'b1;
            if (!w_done && cyc >= w_dly) s_axi_wvalid = 1'b1;
        end
        check("aw_w_handshake", {30'd0, aw_done, w_done}, 32'h3);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        cyc = 0;
        while (!s_axi_bvalid && cyc < 20) begin
            if (s_axi_awready || s_axi_wready) viol++;
            @(negedge ACLK);
            cyc++;
        end
        check("bvalid_arrives", {31'd0, s_axi_bvalid}, 32'h1);
        resp = s_axi_bresp;
        for (int i = 0; i < b_hold; i++) begin
            if (!s_axi_bvalid || s_axi_bresp !== resp || s_axi_awready || s_axi_wready) viol++;
            @(negedge ACLK);
        end
        s_axi_bready = 1'b1;
        @(negedge ACLK);
        s_axi_bready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (s_axi_bvalid) viol++;
            @(negedge ACLK);
        end
        check("write_channel_rules", 32'(viol), 32'h0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int r_hold,
                            output logic [31:0] data, output logic [1:0] resp);
        int cyc;
        int viol;
        viol = 0; cyc = 0;
        @(negedge ACLK);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && cyc < 20) begin
            @(negedge ACLK);
            cyc++;
        end
        check("arready_seen", {31'd0, s_axi_arready}, 32'h1);
        @(negedge ACLK);
        s_axi_arvalid = 1'b0;
        check("rvalid_arrives", {31'd0, s_axi_rvalid}, 32'h1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        if (s_axi_arready) viol++;
        for (int i = 0; i < r_hold; i++) begin
            @(negedge ACLK);
            if (!s_axi_rvalid || s_axi_rdata !== data || s_axi_rresp !== resp || s_axi_arready) viol++;
        end
        s_axi_rready = 1'b1;
        @(negedge ACLK);
        s_axi_rready = 1'b0;
        if (s_axi_rvalid) viol++;
        check("read_channel_rules", 32'(viol), 32'h0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_hold);
        logic [1:0] resp, exp_resp;
        model_write(addr, data, strb, exp_resp);
        axi_write(addr, data, strb, aw_dly, w_dly, b_hold, resp);
        check("bresp", 32'(resp), 32'(exp_resp));
        check("gpio_o", gpio_o, m_out);
        check("irq", {31'd0, irq}, {31'd0, model_irq()});
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_hold);
        logic [31:0] data, exp_data;
        logic [1:0]  resp, exp_resp;
        model_read(addr, exp_data, exp_resp);
        axi_read(addr, r_hold, data, resp);
        check("rdata", data, exp_data);
        check("rresp", 32'(resp), 32'(exp_resp));
    endtask

    logic [31:0] rnd_addr;
    logic [31:0] rnd_new;
    int          cyc_wait;

    initial begin
        // Reset state
        repeat (3) @(negedge ACLK);
        check("rst_awready", {31'd0, s_axi_awready}, 32'h0);
        check("rst_wready", {31'd0, s_axi_wready}, 32'h0);
        check("rst_arready", {31'd0, s_axi_arready}, 32'h0);
        check("rst_bvalid", {31'd0, s_axi_bvalid}, 32'h0);
        check("rst_rvalid", {31'd0, s_axi_rvalid}, 32'h0);
        check("rst_bresp", 32'(s_axi_bresp), 32'h0);
        check("rst_rresp", 32'(s_axi_rresp), 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_gpio_o", gpio_o, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        ARESET = 1'b0;

        // Full-word write with loopback, then read it back through the synchronizer
        loopback = 1'b1;
        do_write(32'h4000_0000, 32'hDEADA5A5, 4'hF, 0, 0, 0);
        check("t1_gpio", gpio_o, 32'hDEADA5A5);
        repeat (4) @(negedge ACLK);
        m_gpi = m_out;
        do_read(32'h4000_0008, 0);

        // Byte strobe on DATA_OUT, then TOGGLE
        do_write(32'h4000_0000, 32'h0000_0000, 4'hF, 0, 0, 0);
        do_write(32'h4000_0000, 32'h1122_3344, 4'h2, 0, 0, 1);
        check("t2_strobe", gpio_o, 32'h0000_3300);
        do_write(32'h4000_0004, 32'h0000_000F, 4'hF, 1, 0, 0);
        check("t2_toggle", gpio_o, 32'h0000_330F);
        do_read(32'h4000_0004, 1);
        do_write(32'h4000_0000, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
        check("t2_strb_zero", gpio_o, 32'h0000_330F);

        // W leads AW by 3 cycles, B back-pressured for 4 cycles
        do_write(32'h4000_0000, 32'h0000_00A5, 4'hF, 3, 0, 4);

        // Unmapped offsets
        do_read(32'h4000_0014, 0);
        do_write(32'h4000_0018, 32'h1234_5678, 4'hF, 0, 0, 0);
        check("t4_gpio_unchanged", gpio_o, 32'h0000_00A5);

`ifdef GPIO_IRQ_EN
        loopback = 1'b0;
        gpi_drv  = 32'h0;
        repeat (6) @(negedge ACLK);
        m_gpi = 32'h0;
        do_write(32'h4000_000C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(32'h4000_0010, 32'h0000_0001, 4'hF, 0, 0, 0);
        gpi_drv  = 32'h1;
        cyc_wait = 0;
        while (!irq && cyc_wait < 10) begin
            @(negedge ACLK);
            cyc_wait++;
        end
        check("t5_irq_rise", {31'd0, irq}, 32'h1);
        m_status = 32'h1;
        m_gpi    = 32'h1;
        do_read(32'h4000_000C, 0);
        do_write(32'h4000_000C, 32'h0000_0001, 4'hF, 0, 0, 0);
        check("t5_irq_cleared", {31'd0, irq}, 32'h0);
        do_read(32'h4000_000C, 0);
`else
        do_write(32'h4000_0010, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_write(32'h4000_000C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(32'h4000_0010, 0);
        do_read(32'h4000_000C, 0);
`endif

        // Reset while a write response is pending
        @(negedge ACLK);
        check("t6_idle_ready", {30'd0, s_axi_awready, s_axi_wready}, 32'h3);
        s_axi_awaddr  = 32'h4000_0000;
        s_axi_wdata   = 32'h5A5A_1234;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        @(negedge ACLK);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        @(negedge ACLK);
        check("t6_bvalid_pending", {31'd0, s_axi_bvalid}, 32'h1);
        check("t6_gpio_written", gpio_o, 32'h5A5A_1234);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check("t6_bvalid_dropped", {31'd0, s_axi_bvalid}, 32'h0);
        check("t6_gpio_reset", gpio_o, 32'h0);
        m_out = '0; m_status = '0; m_enable = '0;
        do_write(32'h4000_0000, 32'h0000_00FF, 4'hF, 0, 0, 0);

        // Randomized traffic with stable inputs
        loopback = 1'b0;
        gpi_drv  = $urandom;
        repeat (6) @(negedge ACLK);
        m_gpi = gpi_drv;
        do_write(32'h4000_000C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        m_status = '0;
        for (int t = 0; t < 60; t++) begin
            rnd_addr = ($urandom & 32'hFFFF_FFE3) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 1) == 1) begin
                do_write(rnd_addr, $urandom, 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            end else begin
                do_read(rnd_addr, $urandom_range(0, 2));
            end
            if (t == 30) begin
                rnd_new = $urandom;
                gpi_drv = rnd_new;
                repeat (6) @(negedge ACLK);
                if (IRQ_BUILD) m_status = m_status | (rnd_new & ~m_gpi);
                m_gpi = rnd_new;
                check("irq_after_gpi_change", {31'd0, irq}, {31'd0, model_irq()});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
